// File: rtl/optic_tx_sched.sv
// optic_tx_sched: frame scheduler and write arbiter for the optic transmitter payload DPRAM.
//
// Two requesters (ch0 = Vc, DPRAM word 0; ch1 = ST, DPRAM word 1) hand 32-bit words into
// one holding register each. A single write port drains the registers, one word per cycle,
// with round-robin between the two. A periodic trans_start pulse opens a frame, and DPRAM
// writes are held off for BUSY_CYCLES cycles after it. This keeps a consistent Vc/ST pair
// in the DPRAM while the frame is read out.
//
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   enable                    run the scheduler; dropping it stops at the next frame boundary
//   chN_valid/data/ready      requester handshakes (N = 0: Vc, N = 1: ST)
//   inj_comm/crc_fault        fault requests, latched once per frame
//   tx_wea/waddr/wdata        DPRAM write port
//   trans_start               one-cycle frame start pulse
//   tx_comm/crc_fault         frame-latched fault controls
//   stale_flags               bit N set if channel N was not written during the previous frame
//   frame_cnt                 frames started (wrapping)
//   busy                      frame start / readout lock in progress
module optic_tx_sched #(
    parameter int unsigned FRAME_PERIOD = 2500,
    parameter int unsigned BUSY_CYCLES  = 200
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        ch0_valid,
    input  logic [31:0] ch0_data,
    output logic        ch0_ready,
    input  logic        ch1_valid,
    input  logic [31:0] ch1_data,
    output logic        ch1_ready,
    input  logic        inj_comm_fault,
    input  logic        inj_crc_fault,
    output logic        tx_wea,
    output logic        tx_waddr,
    output logic [31:0] tx_wdata,
    output logic        trans_start,
    output logic        tx_comm_fault,
    output logic        tx_crc_fault,
    output logic [1:0]  stale_flags,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(FRAME_PERIOD);
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_PERIOD - 1);
    localparam logic [CntW-1:0] CntBusy = CntW'(BUSY_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StStart, StLock} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       full_q, full_d;
    logic [1:0][31:0] hold_q, hold_d;
    logic             rr_q, rr_d;
    logic [1:0]       fresh_q, fresh_d;
    logic [1:0]       stale_q, stale_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             comm_q, comm_d;
    logic             crc_q, crc_d;
    logic             trans_start_q, trans_start_d;
    logic             busy_q, busy_d;

    logic             wr_en;
    logic             grant;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        hold_d      = hold_q;
        rr_d        = rr_q;
        fresh_d     = fresh_q;
        stale_d     = stale_q;
        frame_cnt_d = frame_cnt_q;
        comm_d      = comm_q;
        crc_d       = crc_q;

        // Write engine: drains one holding register per cycle outside START/LOCK.
        wr_en = ((state_q == StIdle) || (state_q == StWait)) && (full_q != 2'b00);
        grant = (full_q == 2'b11) ? rr_q : full_q[1];
        if (wr_en) begin
            full_d[grant]  = 1'b0;
            fresh_d[grant] = 1'b1;
            rr_d           = ~grant;
        end

        // Accepts only target empty registers, so they never collide with the drain above.
        if (ch0_valid && !full_q[0]) begin
            full_d[0] = 1'b1;
            hold_d[0] = ch0_data;
        end
        if (ch1_valid && !full_q[1]) begin
            full_d[1] = 1'b1;
            hold_d[1] = ch1_data;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == CntLast) begin
                    // Frame-start side effects are committed on entry so they show with the pulse.
                    // fresh_d already includes a write issued in this last WAIT cycle.
                    state_d     = StStart;
                    cnt_d       = '0;
                    stale_d     = ~fresh_d;
                    fresh_d     = 2'b00;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    comm_d      = inj_comm_fault;
                    crc_d       = inj_crc_fault;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStart: begin
                state_d = StLock;
                cnt_d   = cnt_q + CntW'(1);
            end
            StLock: begin
                // The counter keeps running through LOCK so the period stays exact.
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntBusy) begin
                    if (enable) begin
                        state_d = StWait;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        trans_start_d = (state_d == StStart);
        busy_d        = (state_d == StStart) || (state_d == StLock);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            full_q        <= 2'b00;
            hold_q        <= '0;
            rr_q          <= 1'b0;
            fresh_q       <= 2'b00;
            stale_q       <= 2'b00;
            frame_cnt_q   <= 16'd0;
            comm_q        <= 1'b0;
            crc_q         <= 1'b0;
            trans_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            full_q        <= full_d;
            hold_q        <= hold_d;
            rr_q          <= rr_d;
            fresh_q       <= fresh_d;
            stale_q       <= stale_d;
            frame_cnt_q   <= frame_cnt_d;
            comm_q        <= comm_d;
            crc_q         <= crc_d;
            trans_start_q <= trans_start_d;
            busy_q        <= busy_d;
        end
    end

    assign ch0_ready     = ~full_q[0];
    assign ch1_ready     = ~full_q[1];
    assign tx_wea        = wr_en;
    assign tx_waddr      = wr_en ? grant : 1'b0;
    assign tx_wdata      = wr_en ? hold_q[grant] : 32'd0;
    assign trans_start   = trans_start_q;
    assign busy          = busy_q;
    assign stale_flags   = stale_q;
    assign frame_cnt     = frame_cnt_q;
    assign tx_comm_fault = comm_q;
    assign tx_crc_fault  = crc_q;

endmodule
